// File: rtl/rnd_frame_source.sv
// Per-frame random word source for xorexpand.
// Advances a persistent LFSR STEPS times per request, then hands off r.
`ifndef RNDSIZE
`define RNDSIZE 8
`endif

module rnd_frame_source #(
   parameter int                  STEPS        = 4,
   parameter logic [`RNDSIZE-1:0] DEFAULT_SEED = `RNDSIZE'h01
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                seed_valid,
   input  logic [`RNDSIZE-1:0] seed,
   input  logic                req,
   input  logic [1:0]          prob_in,
   output logic                busy,
   output logic [`RNDSIZE-1:0] r,
   output logic [1:0]          probability,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [15:0]         frame_cnt
);

   localparam int W = `RNDSIZE;
   localparam logic [7:0] STEPS_C = 8'(STEPS);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ADVANCE = 2'd1,
      VALID   = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   s_q, s_d;
   logic [W-1:0]   r_q, r_d;
   logic [7:0]     cnt_q, cnt_d;
   logic [1:0]     prob_q, prob_d;
   logic           out_valid_q, out_valid_d;
   logic           busy_q, busy_d;
   logic [15:0]    frame_cnt_q, frame_cnt_d;
   logic [W-1:0]   s_next;

   // Same polynomial as xorexpand, so both ends agree on the sequence.
   always_comb begin
      s_next = {s_q[W-2:0], s_q[W-1] ^ s_q[3] ^ s_q[2] ^ s_q[0]};
   end

   always_comb begin
      state_d     = state_q;
      s_d         = s_q;
      r_d         = r_q;
      cnt_d       = cnt_q;
      prob_d      = prob_q;
      out_valid_d = out_valid_q;
      frame_cnt_d = frame_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (seed_valid) begin
               s_d = (seed == '0) ? DEFAULT_SEED : seed;
            end else if (req) begin
               prob_d  = prob_in;
               cnt_d   = STEPS_C;
               state_d = ADVANCE;
            end
         end
         ADVANCE: begin
            s_d   = s_next;
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
               r_d         = s_next;
               out_valid_d = 1'b1;
               state_d     = VALID;
            end
         end
         VALID: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               frame_cnt_d = frame_cnt_q + 16'd1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         s_q         <= DEFAULT_SEED;
         r_q         <= '0;
         cnt_q       <= '0;
         prob_q      <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         s_q         <= s_d;
         r_q         <= r_d;
         cnt_q       <= cnt_d;
         prob_q      <= prob_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign busy        = busy_q;
   assign r           = r_q;
   assign probability = prob_q;
   assign out_valid   = out_valid_q;
   assign frame_cnt   = frame_cnt_q;

endmodule
